icache_nway: RTL

- Clocked, parametrised successor to the team's combinational instruction cache.
- N-way set-associative instruction tag store with true-LRU replacement.
- Handshaked command interface using the trace-file op codes (8/3/2), a next-level line-fill request/response port, and hit/miss/read/eviction statistics outputs.
- Sits between the trace driver and the L2 model; data payload is not stored (tag/valid/LRU only).

---
 rtl/icache_nway.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative instruction tag store with true-LRU
// replacement. It holds only tag, valid and age state; line data lives in the
// next level. One command is in flight at a time: IDLE accepts it, LOOKUP
// resolves it, and a fetch miss goes through MISS_REQ/MISS_WAIT to install
// the line. CLEAR sweeps one set per cycle, after reset or on a RESET command.

module icache_nway #(
    parameter int ADDR_W      = 32,
    parameter int OFFSET_BITS = 6,
    parameter int INDEX_BITS  = 14,
    parameter int WAYS        = 2,
    parameter int CNT_W       = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [3:0]                cmd_op,
    input  logic [ADDR_W-1:0]         cmd_addr,
    output logic                      rsp_valid,
    output logic                      rsp_hit,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_W-OFFSET_BITS-1:0] mem_req_addr,
    input  logic                      mem_rsp_valid,
    output logic                      busy,
    output logic [CNT_W-1:0]          reads,
    output logic [CNT_W-1:0]          hits,
    output logic [CNT_W-1:0]          misses,
    output logic [CNT_W-1:0]          evictions
);

    localparam int SETS   = 1 << INDEX_BITS;
    localparam int LINE_W = ADDR_W - OFFSET_BITS;
    localparam int TAG_W  = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Command op codes shared with the trace-file format.
    localparam logic [3:0] OP_RESET = 4'd8;
    localparam logic [3:0] OP_INVAL = 4'd3;
    localparam logic [3:0] OP_FETCH = 4'd2;

    // Age value that marks the least recently used way of a set.
    localparam logic [AGE_W-1:0] AGE_LRU = AGE_W'(WAYS - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic                    r_busy;      // sweep armed; also the busy output
    logic [INDEX_BITS-1:0]   r_clr_idx;   // set being cleared
    logic [3:0]              r_op;        // op of the command in flight
    logic [LINE_W-1:0]       r_line;      // line address of the command in flight
    logic [AGE_W-1:0]        r_victim;    // way chosen for the pending fill
    logic [CNT_W-1:0]        r_reads;
    logic [CNT_W-1:0]        r_hits;
    logic [CNT_W-1:0]        r_misses;
    logic [CNT_W-1:0]        r_evictions;

    // Tag store, one word per set.
    logic [WAYS-1:0]                 r_valid_mem [SETS];
    logic [WAYS-1:0][TAG_W-1:0]      r_tag_mem   [SETS];
    logic [WAYS-1:0][AGE_W-1:0]      r_age_mem   [SETS];

    // ------------------------------------------------------------------
    // Combinational lookup of the set addressed by the command in flight
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0]           w_index;
    logic [TAG_W-1:0]                w_tag;
    logic [WAYS-1:0]                 w_set_valid;
    logic [WAYS-1:0][TAG_W-1:0]      w_set_tag;
    logic [WAYS-1:0][AGE_W-1:0]      w_set_age;
    logic [WAYS-1:0]                 w_match;
    logic                            w_hit;
    logic [AGE_W-1:0]                w_hit_way;
    logic                            w_has_invalid;
    logic [AGE_W-1:0]                w_invalid_way;
    logic [AGE_W-1:0]                w_lru_way;
    logic [AGE_W-1:0]                w_victim;
    logic [AGE_W-1:0]                w_touch_way;
    logic [WAYS-1:0][AGE_W-1:0]      w_touched_age;

    // Write strobes into the tag store.
    logic w_clr_we;
    logic w_hit_touch_we;
    logic w_inval_we;
    logic w_fill_we;

    // Response decode.
    logic w_lookup_rsp;
    logic w_clear_done_rsp;

    // Byte-offset bits never reach the tag store.
    logic w_unused_offset;
    assign w_unused_offset = ^cmd_addr[OFFSET_BITS-1:0];

    assign w_index     = r_line[INDEX_BITS-1:0];
    assign w_tag       = r_line[LINE_W-1:INDEX_BITS];
    assign w_set_valid = r_valid_mem[w_index];
    assign w_set_tag   = r_tag_mem[w_index];
    assign w_set_age   = r_age_mem[w_index];

    // Tag compare, hit-way encode and victim selection for the current set.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_match       = '0;
        w_hit_way     = '0;
        w_has_invalid = 1'b0;
        w_invalid_way = '0;
        w_lru_way     = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_match[w] = w_set_valid[w] && (w_set_tag[w] == w_tag);
        end
        // Descending scans leave the lowest matching index as the winner.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_match[w]) begin
                w_hit_way = AGE_W'(w);
            end
            if (!w_set_valid[w]) begin
                w_has_invalid = 1'b1;
                w_invalid_way = AGE_W'(w);
            end
            if (w_set_age[w] == AGE_LRU) begin
                w_lru_way = AGE_W'(w);
            end
        end
    end

    assign w_hit    = |w_match;
    assign w_victim = w_has_invalid ? w_invalid_way : w_lru_way;

    // A fill touches the latched victim; a fetch hit touches the hit way.
    assign w_touch_way = (r_state == S_MISS_WAIT) ? r_victim : w_hit_way;

    // True-LRU touch: ways younger than the touched one age by one, it becomes 0.
    always_comb begin
        w_touched_age = w_set_age;
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == w_touch_way) begin
                w_touched_age[w] = '0;
            end else if (w_set_age[w] < w_set_age[w_touch_way]) begin
                w_touched_age[w] = w_set_age[w] + AGE_W'(1);
            end
        end
    end

    assign w_clr_we       = (r_state == S_CLEAR) && r_busy;
    assign w_hit_touch_we = (r_state == S_LOOKUP) && (r_op == OP_FETCH) && w_hit;
    assign w_inval_we     = (r_state == S_LOOKUP) && (r_op == OP_INVAL) && w_hit;
    assign w_fill_we      = (r_state == S_MISS_WAIT) && mem_rsp_valid;

    // ------------------------------------------------------------------
    // Tag store update
    // ------------------------------------------------------------------
    // Tag store writes: sweep, LRU touch on hit, invalidate, line fill.
    // NOTE: the arrays carry no reset; the CLEAR sweep initialises them, which keeps them RAM-mappable.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_valid_mem[r_clr_idx] <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_age_mem[r_clr_idx][w] <= AGE_W'(w);
            end
        end else begin
            if (w_hit_touch_we || w_fill_we) begin
                r_age_mem[w_index] <= w_touched_age;
            end
            if (w_inval_we) begin
                r_valid_mem[w_index][w_hit_way] <= 1'b0;
            end
            if (w_fill_we) begin
                r_valid_mem[w_index][r_victim] <= 1'b1;
                r_tag_mem[w_index][r_victim]   <= w_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and statistics
    // ------------------------------------------------------------------
    // Command sequencing, clear sweep and statistics counters.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_CLEAR;
            r_busy      <= 1'b0;
            r_clr_idx   <= '0;
            r_op        <= '0;
            r_line      <= '0;
            r_victim    <= '0;
            r_reads     <= '0;
            r_hits      <= '0;
            r_misses    <= '0;
            r_evictions <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    // Coming out of reset, the first cycle only arms the sweep.
                    if (!r_busy) begin
                        r_busy <= 1'b1;
                    end else begin
                        r_clr_idx <= r_clr_idx + INDEX_BITS'(1);
                        if (r_clr_idx == '1) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op   <= cmd_op;
                        r_line <= cmd_addr[ADDR_W-1:OFFSET_BITS];
                        case (cmd_op)
                            OP_RESET: begin
                                r_reads     <= '0;
                                r_hits      <= '0;
                                r_misses    <= '0;
                                r_evictions <= '0;
                                r_clr_idx   <= '0;
                                r_busy      <= 1'b1;
                                r_state     <= S_CLEAR;
                            end
                            OP_INVAL: begin
                                r_state <= S_LOOKUP;
                            end
                            OP_FETCH: begin
                                r_reads <= r_reads + CNT_W'(1);
                                r_state <= S_LOOKUP;
                            end
                            default: begin
                                // Unknown ops are consumed without effect.
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end

                S_LOOKUP: begin
                    if (r_op == OP_FETCH && !w_hit) begin
                        r_misses <= r_misses + CNT_W'(1);
                        if (!w_has_invalid) begin
                            r_evictions <= r_evictions + CNT_W'(1);
                        end
                        r_victim <= w_victim;
                        r_state  <= S_MISS_REQ;
                    end else begin
                        if (r_op == OP_FETCH) begin
                            r_hits <= r_hits + CNT_W'(1);
                        end
                        r_state <= S_IDLE;
                    end
                end

                S_MISS_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= S_MISS_WAIT;
                    end
                end

                S_MISS_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state
    // ------------------------------------------------------------------
    assign w_lookup_rsp     = (r_state == S_LOOKUP) &&
                              ((r_op == OP_INVAL) || ((r_op == OP_FETCH) && w_hit));
    assign w_clear_done_rsp = w_clr_we && (r_clr_idx == '1) && (r_op == OP_RESET);

    assign cmd_ready     = (r_state == S_IDLE);
    assign busy          = r_busy;
    assign mem_req_valid = (r_state == S_MISS_REQ);
    assign mem_req_addr  = r_line;
    assign rsp_valid     = w_lookup_rsp || w_fill_we || w_clear_done_rsp;
    assign rsp_hit       = (r_state == S_LOOKUP) && w_hit;
    assign reads         = r_reads;
    assign hits          = r_hits;
    assign misses        = r_misses;
    assign evictions     = r_evictions;

endmodule
